// File: rtl/vec_add.sv
// vec_add: streaming element-wise binary32 adder, c[i] = a[i] + b[i], run as an
// ap_start/ap_done kernel over FIFO-style token streams (bit 32 of a token = EoT).
// Build option: define VEC_ADD_SUBNORM_EN for gradual underflow; otherwise
// subnormal inputs and results are flushed to signed zero.
module vec_add (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [32:0] a_s_dout,
    input  logic        a_s_empty_n,
    output logic        a_s_read,
    input  logic [32:0] b_s_dout,
    input  logic        b_s_empty_n,
    output logic        b_s_read,
    output logic [32:0] c_din,
    input  logic        c_full_n,
    output logic        c_write,
    input  logic [63:0] n
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TOK_W  = DATA_W + 1;
    localparam int unsigned N_W    = 64;
    localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [N_W-1:0]   n_q;
    logic             fire;
    logic             eot;
    logic             unused_n;

    // Leading-zero count of a 27-bit value, MSB first (27 when zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      cnt   = cnt + 5'd1;
            end
        end
        return cnt;
    endfunction

    // binary32 add, round-to-nearest-even; 27-bit magnitudes carry hidden bit at [26] and G/R/S at [2:0].
    function automatic logic [DATA_W-1:0] fadd(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        logic        sa, sb, sx, sy;
        logic        a_nan, b_nan, a_inf, b_inf;
        logic        rnd, flush;
        logic [7:0]  ea, eb, ex, ey, d;
        logic [23:0] ma, mb, mx, my;
        logic [53:0] sh;
        logic [26:0] xa, ya, m;
        logic [27:0] sum;
        logic [4:0]  lz;
        logic [9:0]  e;
        logic [24:0] rounded;
        logic [DATA_W-1:0] res;
`ifdef VEC_ADD_SUBNORM_EN
        logic [4:0]  shamt;
`endif
        sa    = a[31];
        sb    = b[31];
        ea    = a[30:23];
        eb    = b[30:23];
        a_nan = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (eb == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (eb == 8'hFF) && (b[22:0] == 23'd0);
        flush = 1'b0;
        res   = '0;
`ifdef VEC_ADD_SUBNORM_EN
        // Subnormals: hidden bit 0 at exponent 1.
        ma = {(ea != 8'd0), a[22:0]};
        mb = {(eb != 8'd0), b[22:0]};
        if (ea == 8'd0) ea = 8'd1;
        if (eb == 8'd0) eb = 8'd1;
`else
        // Subnormal inputs collapse to signed zero.
        ma = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
`endif
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            res = QNAN;
        end else if (a_inf) begin
            res = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            res = {sb, 8'hFF, 23'd0};
        end else begin
            // Order operands so x has the larger magnitude.
            if ({ea, ma} >= {eb, mb}) begin
                sx = sa; ex = ea; mx = ma;
                sy = sb; ey = eb; my = mb;
            end else begin
                sx = sb; ex = eb; mx = mb;
                sy = sa; ey = ea; my = ma;
            end
            d = ex - ey;
            if (d > 8'd27) d = 8'd27;
            sh = {my, 3'b000, 27'd0} >> d;
            xa = {mx, 3'b000};
            ya = {sh[53:28], sh[27] | (|sh[26:0])};
            if (sx == sy) sum = {1'b0, xa} + {1'b0, ya};
            else          sum = {1'b0, xa} - {1'b0, ya};
            e  = {2'b00, ex};
            lz = 5'd0;
            if (sum == 28'd0) begin
                // Only equal-sign negative zeros keep the minus sign.
                res = {sa & sb, 31'd0};
            end else begin
                if (sum[27]) begin
                    m = {sum[27:2], sum[1] | sum[0]};
                    e = e + 10'd1;
                end else begin
                    m  = sum[26:0];
                    lz = lzc27(m);
`ifdef VEC_ADD_SUBNORM_EN
                    // Stop normalising at exponent 1; what remains is subnormal.
                    shamt = (10'(lz) < (e - 10'd1)) ? lz : 5'(e - 10'd1);
                    m = m << shamt;
                    e = e - 10'(shamt);
`else
                    if (10'(lz) >= e) flush = 1'b1;
                    m = m << lz;
                    e = e - 10'(lz);
`endif
                end
                rnd     = m[2] & (m[1] | m[0] | m[3]);
                rounded = {1'b0, m[26:3]} + 25'(rnd);
                if (rounded[24]) begin
                    rounded = {1'b0, rounded[24:1]};
                    e       = e + 10'd1;
                end
                if (flush)
                    res = {sx, 31'd0};
                else if (e >= 10'd255)
                    res = {sx, 8'hFF, 23'd0};
                else
                    res = {sx, (rounded[23] ? e[7:0] : 8'd0), rounded[22:0]};
            end
        end
        return res;
    endfunction

    assign eot  = a_s_dout[32] | b_s_dout[32];
    assign fire = !ap_rst && (state_q == S_RUN) && a_s_empty_n && b_s_empty_n && c_full_n;

    assign a_s_read = fire;
    assign b_s_read = fire;
    assign c_write  = fire;

    assign ap_idle  = (state_q == S_IDLE) || ap_rst;
    assign ap_done  = (state_q == S_DONE) && !ap_rst;
    assign ap_ready = ap_done;

    // Element count is latched for visibility only; it never steers the run.
    assign unused_n = ^n_q;

    // Kernel control: IDLE -> RUN on start, RUN -> DONE on forwarding EoT, DONE -> IDLE.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        state_q <= S_RUN;
                        n_q     <= n;
                    end
                end
                S_RUN: begin
                    if (fire && eot) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Output token: zero-latency sum, or a bare EoT marker when either head ends the transfer.
    always_comb begin
        c_din = '0;
        if (!ap_rst) begin
            if (eot) c_din = {1'b1, 32'd0};
            else     c_din = TOK_W'({1'b0, fadd(a_s_dout[31:0], b_s_dout[31:0])});
        end
    end

endmodule

// File: tb/tb_vec_add.sv
// tb_vec_add: directed-vector bench for vec_add with FIFO-style stream models.
module tb_vec_add;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [32:0] a_s_dout, b_s_dout, c_din;
    logic        a_s_empty_n, b_s_empty_n, c_full_n;
    logic        a_s_read, b_s_read, c_write;
    logic [63:0] n;

    logic [32:0] qa[$], qb[$], got[$], exp_q[$];
    logic        a_vld, b_vld;
    logic [32:0] a_head, b_head;
    logic        hold_a, hold_b, hold_c;
    logic        nx_rst, nx_start, nx_hold_a, nx_hold_b, nx_hold_c;
    logic        rd_a, rd_b, wr_c;
    logic [32:0] cd_s;
    int          checks, errors;

    localparam logic [32:0] EOT = {1'b1, 32'd0};

    vec_add dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .a_s_dout    (a_s_dout),
        .a_s_empty_n (a_s_empty_n),
        .a_s_read    (a_s_read),
        .b_s_dout    (b_s_dout),
        .b_s_empty_n (b_s_empty_n),
        .b_s_read    (b_s_read),
        .c_din       (c_din),
        .c_full_n    (c_full_n),
        .c_write     (c_write),
        .n           (n)
    );

    always #5 ap_clk = ~ap_clk;

    assign a_s_dout    = a_head;
    assign b_s_dout    = b_head;
    assign a_s_empty_n = a_vld & ~hold_a;
    assign b_s_empty_n = b_vld & ~hold_b;
    assign c_full_n    = ~hold_c;

    task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] req);
        checks++;
        if (obs !== req) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, req);
        end
    endtask

    function automatic void refresh();
        a_vld  = (qa.size() != 0);
        b_vld  = (qb.size() != 0);
        a_head = a_vld ? qa[0] : 33'd0;
        b_head = b_vld ? qb[0] : 33'd0;
    endfunction

    function automatic void push_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        qa.push_back({1'b0, a});
        qb.push_back({1'b0, b});
        exp_q.push_back({1'b0, c});
    endfunction

    function automatic void push_eot();
        qa.push_back(EOT);
        qb.push_back(EOT);
        exp_q.push_back(EOT);
    endfunction

    function automatic void clear_all();
        qa.delete();
        qb.delete();
        got.delete();
        exp_q.delete();
        refresh();
    endfunction

    // One clock: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
    task automatic tick();
        @(posedge ap_clk);
        #1;
        if (rd_a && qa.size() != 0) void'(qa.pop_front());
        if (rd_b && qb.size() != 0) void'(qb.pop_front());
        if (wr_c) got.push_back(cd_s);
        ap_rst   = nx_rst;
        ap_start = nx_start;
        hold_a   = nx_hold_a;
        hold_b   = nx_hold_b;
        hold_c   = nx_hold_c;
        refresh();
        @(negedge ap_clk);
        rd_a = a_s_read;
        rd_b = b_s_read;
        wr_c = c_write;
        cd_s = c_din;
    endtask

    // hold_sel: 0 none, 1 output full, 2 stream b empty; applied for hold_len cycles from hold_at.
    task automatic run_scenario(input string tag, input int hold_sel, input int hold_at, input int hold_len);
        int eot_cyc;
        int done_cyc;
        eot_cyc  = -1;
        done_cyc = -1;
        n        = 64'(exp_q.size() - 1);
        got.delete();
        nx_start = 1'b1;
        tick();
        nx_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            nx_hold_c = (hold_sel == 1) && (c >= hold_at) && (c < hold_at + hold_len);
            nx_hold_b = (hold_sel == 2) && (c >= hold_at) && (c < hold_at + hold_len);
            tick();
            if (hold_c || hold_b)
                check_eq($sformatf("%s_stall_c%0d", tag, c), 33'({a_s_read, b_s_read, c_write}), 33'd0);
            if (c_write && c_din[32] && eot_cyc < 0) eot_cyc = c;
            if (ap_done) begin
                done_cyc = c;
                check_eq({tag, "_ready"}, 33'(ap_ready), 33'd1);
                break;
            end
        end
        nx_hold_b = 1'b0;
        nx_hold_c = 1'b0;
        check_eq({tag, "_done_seen"}, 33'(done_cyc >= 0), 33'd1);
        check_eq({tag, "_done_lat"}, 33'(done_cyc - eot_cyc), 33'd1);
        tick();
        check_eq({tag, "_idle_after"}, 33'({ap_idle, ap_done, ap_ready}), 33'b100);
        check_eq({tag, "_len"}, 33'(got.size()), 33'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_eq($sformatf("%s_tok%0d", tag, i), got[i], exp_q[i]);
    endtask

    function automatic void load_basic();
        clear_all();
        push_vec(32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000);
        push_vec(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        push_vec(32'h4000_0000, 32'h4040_0000, 32'h40A0_0000);
        push_vec(32'h4040_0000, 32'h4080_0000, 32'h40E0_0000);
        push_vec(32'h4080_0000, 32'h40A0_0000, 32'h4110_0000);
        push_eot();
    endfunction

    initial begin
        checks    = 0;
        errors    = 0;
        ap_rst    = 1'b1;
        ap_start  = 1'b0;
        hold_a    = 1'b0;
        hold_b    = 1'b0;
        hold_c    = 1'b0;
        n         = 64'd0;
        nx_rst    = 1'b1;
        nx_start  = 1'b0;
        nx_hold_a = 1'b0;
        nx_hold_b = 1'b0;
        nx_hold_c = 1'b0;
        rd_a      = 1'b0;
        rd_b      = 1'b0;
        wr_c      = 1'b0;
        cd_s      = '0;
        clear_all();

        // Reset state with valid heads present.
        push_vec(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        refresh();
        tick();
        tick();
        check_eq("rst_strobes", 33'({a_s_read, b_s_read, c_write, ap_done, ap_ready}), 33'd0);
        check_eq("rst_idle", 33'(ap_idle), 33'd1);
        check_eq("rst_cdin", c_din, 33'd0);
        nx_rst = 1'b0;
        tick();
        check_eq("post_rst_idle", 33'({ap_idle, ap_done, a_s_read}), 33'b100);

        // Basic run.
        load_basic();
        run_scenario("basic", 0, 0, 0);

        // Output backpressure mid-stream.
        load_basic();
        run_scenario("bkpr", 1, 2, 3);

        // Stream b starves while a is valid.
        clear_all();
        push_vec(32'h4040_0000, 32'h4080_0000, 32'h40E0_0000);
        push_eot();
        run_scenario("skew", 2, 0, 4);

        // Special values and rounding corners.
        clear_all();
        push_vec(32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
        push_vec(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
        push_vec(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        push_vec(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
        push_vec(32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
        push_vec(32'h7F80_0001, 32'h0000_0000, 32'h7FC0_0000);
        push_vec(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000);
        push_vec(32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        push_vec(32'h8000_0000, 32'h0000_0000, 32'h0000_0000);
        push_vec(32'h4040_0000, 32'hC000_0000, 32'h3F80_0000);
        push_vec(32'h3F80_0000, 32'hB380_0000, 32'h3F7F_FFFF);
        push_vec(32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000);
`ifdef VEC_ADD_SUBNORM_EN
        push_vec(32'h0040_0000, 32'h0000_0000, 32'h0040_0000);
        push_vec(32'h0080_0001, 32'h8080_0000, 32'h0000_0001);
`else
        push_vec(32'h0040_0000, 32'h0000_0000, 32'h0000_0000);
        push_vec(32'h0080_0001, 32'h8080_0000, 32'h0000_0000);
`endif
        push_eot();
        run_scenario("spec", 0, 0, 0);

        // Reset after two tokens, then a fresh run.
        clear_all();
        push_vec(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        push_vec(32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        push_vec(32'h4040_0000, 32'h4040_0000, 32'h40C0_0000);
        push_eot();
        refresh();
        nx_start = 1'b1;
        tick();
        nx_start = 1'b0;
        tick();
        tick();
        nx_rst = 1'b1;
        tick();
        check_eq("midrst_strobes", 33'({a_s_read, b_s_read, c_write, ap_idle}), 33'b0001);
        check_eq("midrst_cdin", c_din, 33'd0);
        nx_rst = 1'b0;
        tick();
        check_eq("midrst_after", 33'({a_s_read, b_s_read, c_write, ap_idle}), 33'b0001);
        check_eq("midrst_len", 33'(got.size()), 33'd2);
        if (got.size() == 2) begin
            check_eq("midrst_tok0", got[0], {1'b0, 32'h4000_0000});
            check_eq("midrst_tok1", got[1], {1'b0, 32'h4080_0000});
        end
        clear_all();
        push_vec(32'h4000_0000, 32'h3F00_0000, 32'h4020_0000);
        push_eot();
        run_scenario("rerun", 0, 0, 0);

        // Mismatched EoT: a ends while b still holds 7.0; both pop once.
        clear_all();
        qa.push_back(EOT);
        qb.push_back({1'b0, 32'h40E0_0000});
        qb.push_back({1'b0, 32'h4000_0000});
        exp_q.push_back(EOT);
        refresh();
        run_scenario("mism", 0, 0, 0);
        check_eq("mism_a_left", 33'(qa.size()), 33'd0);
        check_eq("mism_b_left", 33'(qb.size()), 33'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
